// File: rtl/unified_mem_arbiter.sv
// Two-master arbiter that shares one memory data port between instruction
// fetch and data load/store. A starvation counter bounds how long fetch can lose.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  input  logic [2:0]            d_load_type,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_we,
  output logic [3:0]            m_be,
  output logic                  m_re,
  output logic [2:0]            m_load_type,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic [3:0]            dbg_starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                  gnt_i, gnt_d;
  logic [3:0]            starve_q, starve_d;
  logic                  i_rvalid_q, d_rvalid_q;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  // Handshake: req is held by the master; it is accepted in the cycle its
  // ready is high (ready is combinational, never both high, low in reset).
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      if (i_req && (!d_req || starve_q == LIMIT)) gnt_i = 1'b1;
      else if (d_req)                               gnt_d = 1'b1;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (i_req && !gnt_i) starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
  end

  always_comb begin
    m_addr      = '0;
    m_wdata     = '0;
    m_we        = 1'b0;
    m_be        = 4'b0000;
    m_re        = 1'b0;
    m_load_type = 3'b000;
    if (gnt_i) begin
      m_addr      = {i_addr[ADDR_WIDTH-1:2], 2'b00};
      m_re        = 1'b1;
      m_load_type = 3'b010;
    end else if (gnt_d) begin
      m_addr = d_addr;
      if (d_we) begin
        m_we    = 1'b1;
        m_be    = d_be;
        m_wdata = d_wdata;
      end else begin
        m_re        = 1'b1;
        m_load_type = d_load_type;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= 4'd0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      i_rvalid_q <= gnt_i;
      d_rvalid_q <= gnt_d;
      if (gnt_i) i_rdata_q <= m_rdata;
      // Stores acknowledge with zero data so d_rdata never leaks stale loads.
      if (gnt_d) d_rdata_q <= d_we ? '0 : m_rdata;
    end
  end

  assign i_ready          = gnt_i;
  assign d_ready          = gnt_d;
  assign i_rvalid         = i_rvalid_q;
  assign i_rdata          = i_rdata_q;
  assign d_rvalid         = d_rvalid_q;
  assign d_rdata          = d_rdata_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level reference of the grant and response rules.
module tb_unified_mem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [2:0]  d_load_type = '0;
  logic        i_ready, i_rvalid, d_ready, d_rvalid, m_we, m_re;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be, dbg_starve;
  logic [2:0]  m_load_type;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_load_type(d_load_type), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_be(m_be), .m_re(m_re),
    .m_load_type(m_load_type), .m_rdata(m_rdata), .dbg_starve_cnt_o(dbg_starve)
  );

  // clock / environment memory
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end
  assign m_rdata = mem[m_addr[9:2]];

  // reference model state and scoreboard
  logic [31:0] ref_mem [256];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] i_hold, d_hold;
  int          m_starve;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_i_q.delete();
    exp_d_q.delete();
    i_hold   = '0;
    d_hold   = '0;
    m_starve = 0;
  endtask

  // One bus cycle: drive at negedge, check, then advance the reference.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic [2:0] dlt);
    logic gi, gd;
    logic [31:0] w;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
    d_addr = da; d_wdata = dwd; d_be = dbe; d_load_type = dlt;
    #1;
    gi = ir && (!dr || m_starve == LIM);
    gd = dr && !gi;
    chk("i_ready", i_ready, gi);
    chk("d_ready", d_ready, gd);
    chk("starve", dbg_starve, m_starve);
    if (gi) begin
      chk("m_addr_i", m_addr, {ia[31:2], 2'b00});
      chk("m_ctl_i", {m_re, m_we, m_be, m_load_type}, {1'b1, 1'b0, 4'b0000, 3'b010});
    end else if (gd && !dwe) begin
      chk("m_addr_ld", m_addr, da);
      chk("m_ctl_ld", {m_re, m_we, m_be, m_load_type}, {1'b1, 1'b0, 4'b0000, dlt});
    end else if (gd) begin
      chk("m_addr_st", m_addr, da);
      chk("m_ctl_st", {m_re, m_we, m_be}, {1'b0, 1'b1, dbe});
      chk("m_wdata_st", m_wdata, dwd);
    end else begin
      chk("m_idle", {m_addr, m_wdata, m_re, m_we, m_be, m_load_type}, '0);
    end
    chk("i_rvalid", i_rvalid, exp_i_q.size() != 0);
    if (exp_i_q.size() != 0) i_hold = exp_i_q.pop_front();
    chk("i_rdata", i_rdata, i_hold);
    chk("d_rvalid", d_rvalid, exp_d_q.size() != 0);
    if (exp_d_q.size() != 0) d_hold = exp_d_q.pop_front();
    chk("d_rdata", d_rdata, d_hold);
    if (gi) exp_i_q.push_back(ref_mem[ia[9:2]]);
    if (gd) begin
      if (dwe) begin
        exp_d_q.push_back('0);
        w = ref_mem[da[9:2]];
        for (int b = 0; b < 4; b++) if (dbe[b]) w[8*b +: 8] = dwd[8*b +: 8];
        ref_mem[da[9:2]] = w;
      end else begin
        exp_d_q.push_back(ref_mem[da[9:2]]);
      end
    end
    if (ir && !gi) m_starve = (m_starve >= LIM) ? LIM : m_starve + 1;
    else           m_starve = 0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'b0, 3'b0);
  endtask

  initial begin
    logic [2:0] lts [5];
    lts[0] = 3'b000; lts[1] = 3'b001; lts[2] = 3'b010; lts[3] = 3'b100; lts[4] = 3'b101;
    model_reset();
    // preload memory while reset holds the bus idle
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = 8'(k);
      pre_dat = (k == 64) ? 32'hDEADBEEF : (k == 0) ? 32'h000000FF : $urandom;
      ref_mem[k] = pre_dat;
    end
    @(negedge clk);
    pre_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rst_ready", {i_ready, d_ready}, 2'b00);
    chk("rst_m", {m_re, m_we}, 2'b00);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("rst_starve", dbg_starve, 4'd0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // fetch at unaligned address is word-aligned on the bus
    cycle(1'b1, 32'h103, 1'b0, 1'b0, '0, '0, 4'b0, 3'b0);
    chk("fetch_maddr", m_addr, 32'h100);
    idle();
    chk("fetch_rvalid", i_rvalid, 1'b1);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);

    // LBU passes address unaligned, returns raw memory data
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h2001, '0, 4'b0, 3'b100);
    chk("lbu_maddr", m_addr, 32'h2001);
    idle();
    chk("lbu_rdata", {d_rvalid, d_rdata}, {1'b1, 32'h000000FF});

    // store acknowledges with zero data
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h2002, 32'h1234, 4'b0011, 3'b0);
    chk("st_bus", {m_we, m_be, m_addr}, {1'b1, 4'b0011, 32'h2002});
    idle();
    chk("st_ack", {d_rvalid, d_rdata, i_rvalid}, {1'b1, 32'd0, 1'b0});

    // starvation pattern with both masters loading continuously
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'h40 + 32'(4 * k), 1'b1, 1'b0, 32'h80, '0, 4'b0, 3'b010);
      chk("starve_pat", {i_ready, d_ready}, (k == 4 || k == 9) ? 2'b10 : 2'b01);
    end

    // ten idle cycles
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k > 0) chk("idle_quiet", {m_we, m_re, i_rvalid, d_rvalid}, 4'b0000);
    end

    // reset mid-cycle with starve count raised and a fetch accepted
    cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0, 4'b0, 3'b010);
    cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0, 4'b0, 3'b010);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h14; d_req = 1'b0;
    #1;
    chk("pre_rst_iready", i_ready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    chk("midrst_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("midrst_starve", dbg_starve, 4'd0);
    chk("midrst_ctl", {i_ready, d_ready, m_re, m_we}, 4'b0000);
    @(posedge clk); #1;
    chk("midrst_after_edge", i_rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) idle();

    // random traffic
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)), {22'd0, 8'($urandom), 2'($urandom)},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {22'd0, 8'($urandom), 2'($urandom)}, $urandom, 4'($urandom),
            lts[$urandom_range(0, 4)]);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
